load_value_scheduler: RTL

LOAD_VALUE_SCHEDULER -- requirements
Module: load_value_scheduler

---
 rtl/load_value_scheduler_if.sv | 34 +++
 rtl/load_value_scheduler.sv | 113 +++++++++++
 2 files changed

// File: rtl/load_value_scheduler_if.sv
// ----------------------------------------------------------------------------
// load_value_scheduler_if
// Groups the host write channel, the counter-side reload signals and the
// status outputs of load_value_scheduler into a single bundle.
//   master : host / counter side (drives Wr_Valid, Wr_Data, Count, Underrun_Clr)
//   slave  : scheduler side      (drives Wr_Ready, Load_Value_Valid,
//                                 Load_Value, Fifo_Level, Underrun)
// ----------------------------------------------------------------------------
interface load_value_scheduler_if #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH + 1);

   logic             Wr_Valid;
   logic [WIDTH-1:0] Wr_Data;
   logic             Wr_Ready;
   logic [WIDTH-1:0] Count;
   logic             Load_Value_Valid;
   logic [WIDTH-1:0] Load_Value;
   logic [LW-1:0]    Fifo_Level;
   logic             Underrun;
   logic             Underrun_Clr;

   modport master (
      output Wr_Valid, Wr_Data, Count, Underrun_Clr,
      input  Wr_Ready, Load_Value_Valid, Load_Value, Fifo_Level, Underrun
   );

   modport slave (
      input  Wr_Valid, Wr_Data, Count, Underrun_Clr,
      output Wr_Ready, Load_Value_Valid, Load_Value, Fifo_Level, Underrun
   );
endinterface

// File: rtl/load_value_scheduler.sv
// ----------------------------------------------------------------------------
// load_value_scheduler
// Buffers host-supplied load values in a small FIFO and hands the oldest one
// to a downstream counter each time the counter reaches TRIGGER. A reload
// request that finds the FIFO empty raises a sticky Underrun flag.
//
// Ports
//   Clk   : single clock, rising edge
//   Rst_l : asynchronous active-low reset
//   bus   : load_value_scheduler_if.slave
//           Wr_Valid/Wr_Data/Wr_Ready  host write handshake
//           Count                      downstream counter value
//           Load_Value_Valid/Load_Value one-cycle load strobe and value
//           Fifo_Level                 number of stored words
//           Underrun/Underrun_Clr      sticky empty-reload flag and its clear
// ----------------------------------------------------------------------------
module load_value_scheduler #(
   parameter int               WIDTH   = 4,
   parameter int               DEPTH   = 4,
   parameter logic [WIDTH-1:0] TRIGGER = {WIDTH{1'b1}}
) (
   input logic                  Clk,
   input logic                  Rst_l,
   load_value_scheduler_if.slave bus
);

   localparam int LW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             r_match_q;
   logic             r_lv_valid;
   logic [WIDTH-1:0] r_lv;
   logic             r_underrun;

   logic w_match;
   logic w_hit;
   logic w_empty;
   logic w_wr_ready;
   logic w_push;
   logic w_pop;

   // Ready depends only on the registered level, never on this cycle's inputs.
   assign w_wr_ready = (r_level != LW'(DEPTH));
   assign w_empty    = (r_level == '0);
   assign w_push     = bus.Wr_Valid && w_wr_ready;

   // Rising-edge detect on the trigger compare: a Count parked at TRIGGER
   // requests only one reload.
   assign w_match = (bus.Count == TRIGGER);
   assign w_hit   = w_match && !r_match_q;

   // Pop decision uses the pre-edge level, so a word written on this edge
   // can never be the one popped on this edge.
   assign w_pop = w_hit && !w_empty;

   // NOTE: storage array has no reset; level and pointers define which
   // entries are meaningful, so clearing the RAM would only cost flops.
   always_ff @(posedge Clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.Wr_Data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge Clk or negedge Rst_l) begin
      if (!Rst_l) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_match_q  <= 1'b0;
         r_lv_valid <= 1'b0;
         r_lv       <= '0;
         r_underrun <= 1'b0;
      end else begin
         r_match_q  <= w_match;
         r_lv_valid <= w_pop;

         // Pointers wrap naturally because DEPTH is a power of two.
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
            r_lv     <= r_mem[r_rd_ptr];
         end

         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase

         // A new underrun on the same edge as a clear wins.
         if (w_hit && w_empty) begin
            r_underrun <= 1'b1;
         end else if (bus.Underrun_Clr) begin
            r_underrun <= 1'b0;
         end
      end
   end

   assign bus.Wr_Ready         = w_wr_ready;
   assign bus.Load_Value_Valid = r_lv_valid;
   assign bus.Load_Value       = r_lv;
   assign bus.Fifo_Level       = r_level;
   assign bus.Underrun         = r_underrun;

endmodule
